mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder_byte_fifo.sv | 47 ++++
 rtl/mem_responder.sv | 99 +++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the memory/IO responder.
package mem_responder_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] addr_t;

  localparam logic READ_SIGNAL  = 1'b0;
  localparam logic WRITE_SIGNAL = 1'b1;

  localparam addr_t IO_BASE   = 32'h0003_0000;
  localparam addr_t IO_DATA   = 32'h0000_0000;
  localparam addr_t IO_STATUS = 32'h0000_0004;
  localparam addr_t NULL_PTR  = 32'h0000_0000;

  // Address bit that steers an access into IO space.
  localparam int IO_SEL_BIT = 17;

endpackage

// File: rtl/mem_responder_if.sv
// Initiator bus plus UART-side byte streams of the responder.
interface mem_responder_if;
  import mem_responder_pkg::*;

  addr_t addr_in;
  logic  r_nw_in;
  byte_t data_in;
  byte_t data_out;
  logic  io_buffer_full;
  logic  tx_valid;
  byte_t tx_data;
  logic  tx_ready;
  logic  rx_valid;
  byte_t rx_data;
  logic  rx_ready;

  modport master (
    output addr_in, r_nw_in, data_in, tx_ready, rx_valid, rx_data,
    input  data_out, io_buffer_full, tx_valid, tx_data, rx_ready
  );

  modport slave (
    input  addr_in, r_nw_in, data_in, tx_ready, rx_valid, rx_data,
    output data_out, io_buffer_full, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/mem_responder_byte_fifo.sv
// Byte FIFO with show-ahead head; a push into a full FIFO lands only if a
// pop frees a slot on the same edge, and a pop of an empty FIFO is ignored.
module byte_fifo
  import mem_responder_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  byte_t            din,
  output byte_t            dout,
  output logic             empty,
  output logic             full,
  output logic [FIFO_AW:0] count
);
  localparam int DEPTH = 1 << FIFO_AW;

  byte_t              mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = count[FIFO_AW];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array: no reset, pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FIFO_AW{1'b0}}, do_push} - {{FIFO_AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Byte-wide RAM plus memory-mapped UART FIFOs answering one access per
// enabled cycle; read data appears on data_out the following cycle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int FIFO_AW     = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic              is_io, is_wr, io_data_hit, io_stat_hit;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_a;
  byte_t             ram [2**RAM_AW];
  byte_t             ram_q, io_q, io_rd_byte;
  logic              sel_ram, tx_ovf, io_full;

  logic              tx_push, tx_push_eff, tx_pop, tx_empty, tx_full;
  logic              rx_push, rx_pop, rx_empty, rx_full, rx_ready_w;
  byte_t             tx_dout, rx_dout;
  logic [FIFO_AW:0]  tx_count, rx_count, tx_cnt_nxt;

  assign is_io       = bus.addr_in[IO_SEL_BIT];
  assign is_wr       = (bus.r_nw_in == WRITE_SIGNAL);
  assign io_data_hit = (bus.addr_in == IO_BASE + IO_DATA);
  assign io_stat_hit = (bus.addr_in == IO_BASE + IO_STATUS);
  assign ram_a       = bus.addr_in[RAM_AW-1:0];
  assign ram_we      = rdy & ~rst & ~is_io & is_wr;

  // FIFO handshakes; everything is frozen while rdy is low.
  assign tx_push     = rdy & is_wr & io_data_hit;
  assign tx_pop      = rdy & ~tx_empty & bus.tx_ready;
  assign tx_push_eff = tx_push & (~tx_full | tx_pop);
  assign tx_cnt_nxt  = tx_count + {{FIFO_AW{1'b0}}, tx_push_eff}
                                - {{FIFO_AW{1'b0}}, tx_pop};
  assign rx_pop      = rdy & ~is_wr & io_data_hit & ~rx_empty;
  // A full rx FIFO still accepts a byte when the initiator frees a slot now.
  assign rx_ready_w  = ~rx_full | rx_pop;
  assign rx_push     = rdy & bus.rx_valid & rx_ready_w;

  assign bus.rx_ready       = rx_ready_w;
  assign bus.tx_valid       = ~tx_empty;
  assign bus.tx_data        = tx_dout;
  assign bus.io_buffer_full = io_full;
  assign bus.data_out       = sel_ram ? ram_q : io_q;

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk, .rst, .push(tx_push), .pop(tx_pop), .din(bus.data_in),
    .dout(tx_dout), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk, .rst, .push(rx_push), .pop(rx_pop), .din(bus.rx_data),
    .dout(rx_dout), .empty(rx_empty), .full(rx_full), .count(rx_count)
  );

  // Single-port RAM with registered read, contents survive reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (ram_we) ram[ram_a] <= bus.data_in;
      ram_q <= ram[ram_a];
    end
  end

  // Byte returned by an IO-space read.
  always_comb begin
    io_rd_byte = '0;
    if (io_data_hit)
      io_rd_byte = rx_empty ? 8'h00 : rx_dout;
    else if (io_stat_hit)
      io_rd_byte = {5'b0, tx_ovf, tx_full, rx_count != '0};
  end

  // Read-source select, IO read byte, sticky overflow and near-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_q    <= '0;
      sel_ram <= 1'b0;
      tx_ovf  <= 1'b0;
      io_full <= 1'b0;
    end else if (rdy) begin
      if (!is_wr) begin
        sel_ram <= ~is_io;
        io_q    <= io_rd_byte;
      end
      if (tx_push & tx_full & ~tx_pop)
        tx_ovf <= 1'b1;
      else if (is_wr & io_stat_hit)
        tx_ovf <= 1'b0;
      io_full <= (DEPTH - int'(tx_cnt_nxt)) <= FULL_MARGIN;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Vector table, directed corner sequences and random traffic against a
// queue-based reference model of the responder.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder #(.RAM_AW(17), .FIFO_AW(4), .FULL_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
  );

  localparam addr_t A_RAM  = 32'h0000_0010;
  localparam addr_t A_DATA = 32'h0003_0000;
  localparam addr_t A_STAT = 32'h0003_0004;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  byte_t ram_m [int];
  byte_t txq[$];
  byte_t rxq[$];
  bit    m_ovf = 0, m_iof = 0, m_dk = 0;
  byte_t m_dout = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One access cycle: drive, check rx_ready, clock, update model, check outputs.
  task automatic step(input bit r, input bit en, input addr_t a, input bit rnw,
                      input byte_t d, input bit txr, input bit rxv, input byte_t rxd);
    bit io, dhit, shit, txp, rxp, rr, rxpush;
    int ri;
    rst = r; rdy = en;
    bus.addr_in = a; bus.r_nw_in = rnw; bus.data_in = d;
    bus.tx_ready = txr; bus.rx_valid = rxv; bus.rx_data = rxd;
    io   = a[17];
    dhit = (a == A_DATA);
    shit = (a == A_STAT);
    rxp  = !r && en && !rnw && dhit && rxq.size() > 0;
    rr   = rxq.size() < 16 || rxp;
    #1;
    if (!r) chk("rx_ready", bus.rx_ready, rr);
    @(posedge clk);
    if (r) begin
      txq.delete(); rxq.delete();
      m_ovf = 0; m_iof = 0; m_dout = 8'h00; m_dk = 1;
    end else if (en) begin
      txp    = txr && txq.size() > 0;
      rxpush = rxv && rr;
      ri     = int'(a[16:0]);
      if (!io && rnw) begin
        ram_m[ri] = d; m_dk = 0;
      end else if (!io) begin
        m_dk = ram_m.exists(ri);
        if (m_dk) m_dout = ram_m[ri];
      end else if (rnw) begin
        m_dk = 0;
      end else if (dhit) begin
        m_dk = 1; m_dout = rxp ? rxq[0] : 8'h00;
      end else if (shit) begin
        m_dk = 1;
        m_dout = 8'h00;
        m_dout[2] = m_ovf;
        m_dout[1] = (txq.size() == 16);
        m_dout[0] = (rxq.size() > 0);
      end else begin
        m_dk = 1; m_dout = 8'h00;
      end
      if (txp) void'(txq.pop_front());
      if (rxp) void'(rxq.pop_front());
      if (io && rnw && dhit) begin
        if (txq.size() < 16) txq.push_back(d);
        else m_ovf = 1;
      end
      if (io && rnw && shit) m_ovf = 0;
      if (rxpush) rxq.push_back(rxd);
      m_iof = (16 - txq.size()) <= 2;
    end
    #1;
    if (m_dk) chk("data_out", bus.data_out, m_dout);
    chk("tx_valid", bus.tx_valid, txq.size() > 0);
    if (txq.size() > 0) chk("tx_data", bus.tx_data, txq[0]);
    chk("io_buffer_full", bus.io_buffer_full, m_iof);
  endtask

  task automatic idle(input bit txr);
    step(0, 1, A_RAM, READ_SIGNAL, 8'h00, txr, 0, 8'h00);
  endtask

  typedef struct {
    bit r; bit en; addr_t a; bit rnw; byte_t d; bit txr; bit rxv; byte_t rxd;
    bit cd; byte_t ed; bit etv; byte_t etd; bit eiof;
  } vec_t;

  vec_t tbl[14];

  initial begin
    rst = 1; rdy = 0;
    bus.addr_in = NULL_PTR; bus.r_nw_in = READ_SIGNAL; bus.data_in = 8'h00;
    bus.tx_ready = 0; bus.rx_valid = 0; bus.rx_data = 8'h00;

    //          r en addr    rnw d      txr rxv rxd    cd ed     etv etd    iof
    tbl[0]  = '{1, 1, NULL_PTR, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0};
    tbl[1]  = '{0, 1, A_RAM,  1, 8'hA5, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0};
    tbl[2]  = '{0, 1, A_RAM,  0, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0};
    tbl[3]  = '{0, 1, A_DATA, 1, 8'h41, 0, 0, 8'h00, 0, 8'h00, 1, 8'h41, 0};
    tbl[4]  = '{0, 1, A_DATA, 1, 8'h42, 0, 0, 8'h00, 0, 8'h00, 1, 8'h41, 0};
    tbl[5]  = '{0, 1, A_RAM,  0, 8'h00, 1, 0, 8'h00, 1, 8'hA5, 1, 8'h42, 0};
    tbl[6]  = '{0, 1, A_RAM,  0, 8'h00, 1, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0};
    tbl[7]  = '{0, 1, A_STAT, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0};
    tbl[8]  = '{0, 1, A_RAM,  0, 8'h00, 0, 1, 8'h55, 1, 8'hA5, 0, 8'h00, 0};
    tbl[9]  = '{0, 1, A_STAT, 0, 8'h00, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 0};
    tbl[10] = '{0, 1, A_DATA, 0, 8'h00, 0, 0, 8'h00, 1, 8'h55, 0, 8'h00, 0};
    tbl[11] = '{0, 1, A_DATA, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0};
    tbl[12] = '{0, 0, A_RAM,  1, 8'h77, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0};
    tbl[13] = '{0, 1, A_RAM,  0, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].en, tbl[i].a, tbl[i].rnw, tbl[i].d,
           tbl[i].txr, tbl[i].rxv, tbl[i].rxd);
      if (tbl[i].cd) chk($sformatf("tbl%0d_dout", i), bus.data_out, tbl[i].ed);
      chk($sformatf("tbl%0d_tx_valid", i), bus.tx_valid, tbl[i].etv);
      if (tbl[i].etv) chk($sformatf("tbl%0d_tx_data", i), bus.tx_data, tbl[i].etd);
      chk($sformatf("tbl%0d_iof", i), bus.io_buffer_full, tbl[i].eiof);
    end

    // tx fill: near-full after 14th write, 17th dropped, overflow then cleared
    step(1, 1, NULL_PTR, 0, 8'h00, 0, 0, 8'h00);
    for (int i = 0; i < 17; i++) begin
      step(0, 1, A_DATA, WRITE_SIGNAL, byte_t'(8'h80 + i), 0, 0, 8'h00);
      if (i == 12) chk("iof_after_13", bus.io_buffer_full, 1'b0);
      if (i == 13) chk("iof_after_14", bus.io_buffer_full, 1'b1);
    end
    step(0, 1, A_STAT, READ_SIGNAL, 8'h00, 0, 0, 8'h00);
    chk("status_full_ovf", bus.data_out, 8'h06);
    chk("tx_head_kept", bus.tx_data, 8'h80);
    step(0, 1, A_STAT, WRITE_SIGNAL, 8'h00, 0, 0, 8'h00);
    step(0, 1, A_STAT, READ_SIGNAL, 8'h00, 0, 0, 8'h00);
    chk("status_ovf_clr", bus.data_out, 8'h02);
    for (int i = 0; i < 17; i++) idle(1);
    chk("tx_drained", bus.tx_valid, 1'b0);

    // rx: two bytes consumed once each, then empty reads return zero
    step(1, 1, NULL_PTR, 0, 8'h00, 0, 0, 8'h00);
    step(0, 1, A_RAM, READ_SIGNAL, 8'h00, 0, 1, 8'h55);
    step(0, 1, A_RAM, READ_SIGNAL, 8'h00, 0, 1, 8'h66);
    step(0, 1, A_STAT, READ_SIGNAL, 8'h00, 0, 0, 8'h00);
    chk("rx_status_ne", bus.data_out, 8'h01);
    step(0, 1, A_DATA, READ_SIGNAL, 8'h00, 0, 0, 8'h00);
    chk("rx_rd1", bus.data_out, 8'h55);
    step(0, 1, A_DATA, READ_SIGNAL, 8'h00, 0, 0, 8'h00);
    chk("rx_rd2", bus.data_out, 8'h66);
    step(0, 1, A_DATA, READ_SIGNAL, 8'h00, 0, 0, 8'h00);
    chk("rx_rd3", bus.data_out, 8'h00);
    step(0, 1, A_STAT, READ_SIGNAL, 8'h00, 0, 0, 8'h00);
    chk("rx_status_e", bus.data_out, 8'h00);

    // full rx FIFO: pop and push on the same edge keep 16 bytes in order
    for (int i = 0; i < 16; i++)
      step(0, 1, A_RAM, READ_SIGNAL, 8'h00, 0, 1, byte_t'(8'h10 + i));
    #1 chk("rx_ready_full", bus.rx_ready, 1'b0);
    step(0, 1, A_DATA, READ_SIGNAL, 8'h00, 0, 1, 8'hEE);
    chk("rx_full_pop", bus.data_out, 8'h10);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, A_DATA, READ_SIGNAL, 8'h00, 0, 0, 8'h00);
      chk($sformatf("rx_full_order%0d", i), bus.data_out,
          (i < 15) ? 32'(8'h11 + i) : 32'hEE);
    end
    step(0, 1, A_DATA, READ_SIGNAL, 8'h00, 0, 0, 8'h00);
    chk("rx_full_after", bus.data_out, 8'h00);

    // reset mid-stream with bytes queued for transmit
    for (int i = 0; i < 5; i++)
      step(0, 1, A_DATA, WRITE_SIGNAL, byte_t'(8'hC0 + i), 0, 0, 8'h00);
    step(0, 1, A_RAM, READ_SIGNAL, 8'h00, 0, 0, 8'h00);
    step(1, 1, A_RAM, READ_SIGNAL, 8'h00, 1, 0, 8'h00);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_dout", bus.data_out, 8'h00);
    idle(1);
    chk("rst_ram_kept", bus.data_out, 8'hA5);
    chk("rst_no_tx", bus.tx_valid, 1'b0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      addr_t a;
      int k;
      bit r, en, txr;
      k = $urandom_range(0, 9);
      case (k)
        0: a = 32'h0000_0010;
        1: a = 32'h0000_0011;
        2: a = 32'h0001_FFFF;
        3: a = 32'h0000_4A55;
        4: a = 32'h0000_0000;
        5, 6: a = A_DATA;
        7: a = A_STAT;
        8: a = 32'h0003_0008;
        default: a = 32'h0002_0000;
      endcase
      r   = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 7) != 0);
      txr = ($urandom_range(0, 9) < (((c / 300) % 2) ? 8 : 2));
      step(r, en, a, 1'($urandom), 8'($urandom), txr,
           1'($urandom_range(0, 2) == 0), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
